// File: rtl/mem_backing_ctrl.sv
// mem_backing_ctrl: single-port word memory behind the memory interface.
// Accepts one read or write per transaction, answers with a one-cycle
// mem_resp exactly LATENCY cycles after acceptance, flags out-of-range
// addresses (oor_err) and conflicting read+write requests (req_err).
// Optional: define MEM_STATS_EN to add saturating rd_count/wr_count outputs.
module mem_backing_ctrl #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              read_req,
    input  logic              write_req,
    input  logic [ADDR_W-1:0] addrout,
    input  logic [DATA_W-1:0] datatomem,
    output logic [DATA_W-1:0] datafrommem,
    output logic              mem_resp,
    output logic              busy,
    output logic              oor_err,
    output logic              req_err
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state;
    state_t              state_nx;
    logic [3:0]          cnt;
    logic                op_rd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                req_both;
    logic                wr_in_range;
    logic [ADDR_W-1:0]   rsp_addr;
    logic                rsp_rd;
    logic                rsp_oor;
    logic [DATA_W-1:0]   rd_word;

    assign accept      = (state == IDLE) && cs && (read_req ^ write_req);
    assign req_both    = (state == IDLE) && cs && read_req && write_req;
    assign wr_in_range = 32'(addrout) < DEPTH;

    // With LATENCY=1 the RESP entry edge is the acceptance edge, so the
    // read address/op must come straight from the inputs rather than the latches.
    assign rsp_addr = (state == IDLE) ? addrout  : addr_q;
    assign rsp_rd   = (state == IDLE) ? read_req : op_rd_q;
    assign rsp_oor  = 32'(rsp_addr) >= DEPTH;
    assign rd_word  = mem[rsp_addr[IDX_W-1:0]];

    assign mem_resp = (state == RESP);
    assign busy     = (state != IDLE);
    assign oor_err  = (state == RESP) && (32'(addr_q) >= DEPTH);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic: accept in IDLE, count down in BUSY, single RESP cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (LATENCY == 1) ? RESP : BUSY;
            BUSY: if (cnt <= 4'd1) state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Transaction latches, latency counter, read data and conflict pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            op_rd_q     <= 1'b0;
            addr_q      <= '0;
            datafrommem <= '0;
            req_err     <= 1'b0;
        end else begin
            req_err <= req_both;
            if (accept) begin
                cnt     <= 4'(LATENCY - 1);
                op_rd_q <= read_req;
                addr_q  <= addrout;
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if ((state_nx == RESP) && (state != RESP) && rsp_rd)
                datafrommem <= rsp_oor ? DATA_W'(16'hDEAD) : rd_word;
        end
    end

    // Array write on the acceptance edge; contents are never reset.
    always_ff @(posedge clk) begin
        if (accept && write_req && wr_in_range)
            mem[addrout[IDX_W-1:0]] <= datatomem;
    end

`ifdef MEM_STATS_EN
    // Saturating completion counters, bumped on the RESP cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == RESP) begin
            if (op_rd_q && (rd_count != '1))  rd_count <= rd_count + 16'd1;
            if (!op_rd_q && (wr_count != '1)) wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_backing_ctrl.sv
// Scoreboard bench for mem_backing_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares on every mem_resp.
module tb_mem_backing_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        read_req = 1'b0;
    logic        write_req = 1'b0;
    logic [13:0] addrout = '0;
    logic [15:0] datatomem = '0;
    logic [15:0] datafrommem;
    logic        mem_resp;
    logic        busy;
    logic        oor_err;
    logic        req_err;
`ifdef MEM_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    mem_backing_ctrl #(
        .ADDR_W(14),
        .DATA_W(16),
        .DEPTH(1024),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cs(cs),
        .read_req(read_req),
        .write_req(write_req),
        .addrout(addrout),
        .datatomem(datatomem),
        .datafrommem(datafrommem),
        .mem_resp(mem_resp),
        .busy(busy),
        .oor_err(oor_err),
        .req_err(req_err)
`ifdef MEM_STATS_EN
        ,
        .rd_count(rd_count),
        .wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        oor;
        int          cy;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_rsp = -1000;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: every mem_resp must match the oldest expected response.
    always @(negedge clk) begin
        if (mem_resp) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rdata", 32'(datafrommem), 32'(e.d));
                chk("oor_err", 32'(oor_err), 32'(e.oor));
                chk("latency_cycle", 32'(cyc), 32'(e.cy));
                chk("resp_spacing", 32'((cyc - last_rsp) >= LAT + 1), 32'd1);
            end
            last_rsp = cyc;
        end
    end

    task automatic idle_bus();
        cs = 1'b0; read_req = 1'b0; write_req = 1'b0;
    endtask

    task automatic wait_resp();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_resp) seen = 1'b1;
        end
        if (!seen) chk("resp_timeout", 32'd0, 32'd1);
        idle_bus();
    endtask

    task automatic access(input logic wr, input logic [13:0] a, input logic [15:0] d,
                          input logic [15:0] exp_d, input logic exp_oor);
        exp_t e;
        @(negedge clk);
        cs = 1'b1; read_req = !wr; write_req = wr; addrout = a; datatomem = d;
        e.d = exp_d; e.oor = exp_oor; e.cy = cyc + LAT;
        q.push_back(e);
        wait_resp();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp", 32'(mem_resp), 32'd0);
        chk("rst_data", 32'(datafrommem), 32'd0);
        idle_bus();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_data", 32'(datafrommem), 32'd0);
        chk("reset_resp", 32'(mem_resp), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_oor", 32'(oor_err), 32'd0);
        chk("reset_reqerr", 32'(req_err), 32'd0);

        // Basic write/read, out-of-range read/write and index aliasing.
        access(1'b1, 14'h0010, 16'hBEEF, 16'h0000, 1'b0);
        access(1'b0, 14'h0010, 16'h0000, 16'hBEEF, 1'b0);
        access(1'b1, 14'h03FF, 16'h5A5A, 16'hBEEF, 1'b0);
        access(1'b0, 14'h03FF, 16'h0000, 16'h5A5A, 1'b0);
        access(1'b0, 14'h3FFF, 16'h0000, 16'hDEAD, 1'b1);
        access(1'b1, 14'h3FFF, 16'h1111, 16'hDEAD, 1'b1);
        access(1'b0, 14'h03FF, 16'h0000, 16'h5A5A, 1'b0);

        // Conflicting request: one-cycle req_err, no access.
        @(negedge clk);
        cs = 1'b1; read_req = 1'b1; write_req = 1'b1; addrout = 14'h0010;
        @(negedge clk);
        chk("req_err_pulse", 32'(req_err), 32'd1);
        chk("req_err_busy", 32'(busy), 32'd0);
        idle_bus();
        @(negedge clk);
        chk("req_err_drop", 32'(req_err), 32'd0);

        // Read without chip select is ignored.
        read_req = 1'b1; addrout = 14'h0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("nocs_busy", 32'(busy), 32'd0);
        end
        idle_bus();

        // Address change after acceptance has no effect; single response.
        access(1'b1, 14'h0005, 16'h1234, 16'h5A5A, 1'b0);
        @(negedge clk);
        cs = 1'b1; read_req = 1'b1; addrout = 14'h0005;
        e.d = 16'h1234; e.oor = 1'b0; e.cy = cyc + LAT;
        q.push_back(e);
        @(negedge clk);
        addrout = 14'h0006;
        @(negedge clk);
        @(negedge clk);
        chk("hold_resp", 32'(mem_resp), 32'd1);
        @(negedge clk);
        idle_bus();
        repeat (6) @(negedge clk);

        // Reset during BUSY of a read aborts it.
        access(1'b1, 14'h0020, 16'h7777, 16'h1234, 1'b0);
        @(negedge clk);
        cs = 1'b1; read_req = 1'b1; addrout = 14'h0020;
        @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        do_reset();
        repeat (5) @(negedge clk);
        access(1'b0, 14'h0020, 16'h0000, 16'h7777, 1'b0);

        // Write accepted before reset stays committed.
        @(negedge clk);
        cs = 1'b1; write_req = 1'b1; addrout = 14'h0021; datatomem = 16'h8888;
        @(negedge clk);
        do_reset();
        access(1'b0, 14'h0021, 16'h0000, 16'h8888, 1'b0);

        // Fresh reset, then 3 writes and 2 reads (one out of range).
        do_reset();
        access(1'b1, 14'h0030, 16'hAAAA, 16'h0000, 1'b0);
        access(1'b1, 14'h0031, 16'hBBBB, 16'h0000, 1'b0);
        access(1'b1, 14'h0032, 16'hCCCC, 16'h0000, 1'b0);
        access(1'b0, 14'h0030, 16'h0000, 16'hAAAA, 1'b0);
        access(1'b0, 14'h3FFF, 16'h0000, 16'hDEAD, 1'b1);
`ifdef MEM_STATS_EN
        @(negedge clk);
        chk("wr_count", 32'(wr_count), 32'd3);
        chk("rd_count", 32'(rd_count), 32'd2);
        force dut.rd_count = 16'hFFFF;
        @(negedge clk);
        release dut.rd_count;
        access(1'b0, 14'h0031, 16'h0000, 16'hBBBB, 1'b0);
        @(negedge clk);
        chk("rd_count_sat", 32'(rd_count), 32'h0000FFFF);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
